multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle RV32I datapath; it is the producer side of the alu_op interface that alu_control decodes.
- Sequences fetch, decode, execute, memory and writeback steps. Drives datapath enables, mux selects and the 2-bit alu_op.
- Stalls on a memory ready handshake.

Parameters:
- STATE_W, 4, width of the state encoding and of dbg_state.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- opcode  input  7  inst[6:0] from the instruction register. Valid from the DECODE cycle onward.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory has completed the current read or write this cycle.
- pc_write  output  1  PC register load enable.
- ir_write  output  1  instruction register and old-PC register load enable.
- adr_src  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- reg_write  output  1  register file write enable.
- alu_src_a  output  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1 register.
- alu_src_b  output  2  ALU B select: 00 = rs2 register, 01 = immediate, 10 = constant 4.
- alu_op  output  2  ALU operation class for alu_control: 00 = add (load/store/address), 01 = branch compare (subtract), 10 = R-type, 11 = I-type.
- result_src  output  2  result select: 00 = ALUOut, 01 = memory data register, 10 = ALU result.
- instr_done  output  1  one-cycle pulse on the final cycle of each instruction.
- illegal  output  1  sticky flag: an unsupported opcode was decoded.
- dbg_state  output  STATE_W  current state.

Behaviour:
- State register uses the asynchronous reset: rst high forces FETCH immediately.
- While rst is high, every output except dbg_state is forced to 0. The sticky illegal flag is also cleared.
- Outputs are Moore-decoded from the state, plus gating by mem_ready and zero where stated below. Any output not listed for a state is 0.
- FETCH (0):
  - mem_read=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - When mem_ready=1: pc_write=1 and ir_write=1, next state DECODE.
  - When mem_ready=0: hold in FETCH with both write enables at 0.
- DECODE (1):
  - alu_src_a=01, alu_src_b=01, alu_op=00. This precomputes the branch target into ALUOut.
  - Next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - anything else -> TRAP
- MEMADR (2):
  - alu_src_a=10, alu_src_b=01, alu_op=00.
  - Next state MEMRD if opcode=0000011, else MEMWR.
- MEMRD (3):
  - mem_read=1, adr_src=1.
  - Holds until mem_ready=1, then goes to MEMWB.
- MEMWB (4):
  - result_src=01, reg_write=1, instr_done=1.
  - Next state FETCH.
- MEMWR (5):
  - mem_write=1, adr_src=1.
  - Holds until mem_ready=1. In the mem_ready cycle instr_done=1, then goes to FETCH.
- EXEC_R (6): alu_src_a=10, alu_src_b=00, alu_op=10. Next state ALUWB.
- EXEC_I (7): alu_src_a=10, alu_src_b=01, alu_op=11. Next state ALUWB.
- ALUWB (8): result_src=00, reg_write=1, instr_done=1. Next state FETCH.
- BEQ (9):
  - alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, instr_done=1.
  - pc_write = zero, sampled in the same cycle.
  - Next state FETCH.
- JAL (10):
  - alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1.
  - Next state ALUWB, which writes oldPC+4 to rd.
- TRAP (11):
  - illegal is set and stays set until rst. All enables are 0.
  - TRAP is absorbing; only rst leaves it.
- Unused encodings 12-15 go to TRAP on the next clock.
- Opcode is sampled only in the DECODE and MEMADR cycles; changes in any other state have no effect.
- A mem_ready that arrives while mem_read and mem_write are both 0 is ignored.
- rst asserted in the middle of a memory wait drops the request combinationally. After release, fetch restarts at FETCH.
- Cycles per instruction with zero-wait memory: lw 5, sw 4, R/I 4, beq 3, jal 4. Each memory wait cycle adds 1.

Test Plan:
- Release reset, mem_ready held 1, opcode=0110011 -> states 0,1,6,8,0. alu_op=10 in EXEC_R, reg_write=1 and instr_done=1 in ALUWB; CPI 4.
- opcode=0000011 with mem_ready low for 2 cycles in MEMRD -> MEMRD held 3 cycles with mem_read=1 and adr_src=1. Then MEMWB with result_src=01 and reg_write=1.
- opcode=1100011, run twice with zero=1 then zero=0 -> BEQ shows alu_op=01 both times. pc_write=1 only when zero=1; FETCH follows in both cases.
- opcode=0010011 -> EXEC_I with alu_src_b=01 and alu_op=11. Sequence 0,1,7,8.
- opcode=1111111 -> TRAP, illegal=1 and stays set across 10 cycles of any opcode. rst pulse -> FETCH and illegal=0.
- Assert rst during MEMWR wait -> mem_write=0 immediately. After release, dbg_state=0 and pc_write=0 until mem_ready.

Source files
------------

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : Main control FSM for the multi-cycle RV32I datapath; sequences
//            fetch/decode/execute/memory/writeback and drives alu_op.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               adr_src,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         result_src,
  output logic               instr_done,
  output logic               illegal,
  output logic [STATE_W-1:0] dbg_state
);

  localparam logic [STATE_W-1:0] C_FETCH  = STATE_W'(0);
  localparam logic [STATE_W-1:0] C_DECODE = STATE_W'(1);
  localparam logic [STATE_W-1:0] C_MEMADR = STATE_W'(2);
  localparam logic [STATE_W-1:0] C_MEMRD  = STATE_W'(3);
  localparam logic [STATE_W-1:0] C_MEMWB  = STATE_W'(4);
  localparam logic [STATE_W-1:0] C_MEMWR  = STATE_W'(5);
  localparam logic [STATE_W-1:0] C_EXEC_R = STATE_W'(6);
  localparam logic [STATE_W-1:0] C_EXEC_I = STATE_W'(7);
  localparam logic [STATE_W-1:0] C_ALUWB  = STATE_W'(8);
  localparam logic [STATE_W-1:0] C_BEQ    = STATE_W'(9);
  localparam logic [STATE_W-1:0] C_JAL    = STATE_W'(10);
  localparam logic [STATE_W-1:0] C_TRAP   = STATE_W'(11);

  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [6:0] C_OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] C_OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OP_JAL    = 7'b1101111;

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next_state;
  logic               r_illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= C_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Set on the edge that enters TRAP so the flag is visible in the TRAP cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_illegal <= 1'b0;
    end else if (w_next_state == C_TRAP) begin
      r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next_state = C_TRAP;
    case (r_state)
      C_FETCH:  w_next_state = mem_ready ? C_DECODE : C_FETCH;
      C_DECODE: begin
        case (opcode)
          C_OP_LOAD,
          C_OP_STORE:  w_next_state = C_MEMADR;
          C_OP_RTYPE:  w_next_state = C_EXEC_R;
          C_OP_ITYPE:  w_next_state = C_EXEC_I;
          C_OP_BRANCH: w_next_state = C_BEQ;
          C_OP_JAL:    w_next_state = C_JAL;
          default:     w_next_state = C_TRAP;
        endcase
      end
      C_MEMADR: w_next_state = (opcode == C_OP_LOAD) ? C_MEMRD : C_MEMWR;
      C_MEMRD:  w_next_state = mem_ready ? C_MEMWB : C_MEMRD;
      C_MEMWB:  w_next_state = C_FETCH;
      C_MEMWR:  w_next_state = mem_ready ? C_FETCH : C_MEMWR;
      C_EXEC_R: w_next_state = C_ALUWB;
      C_EXEC_I: w_next_state = C_ALUWB;
      C_ALUWB:  w_next_state = C_FETCH;
      C_BEQ:    w_next_state = C_FETCH;
      C_JAL:    w_next_state = C_ALUWB;
      default:  w_next_state = C_TRAP;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    instr_done = 1'b0;
    case (r_state)
      C_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_write   = mem_ready;
        ir_write   = mem_ready;
      end
      C_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      C_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      C_MEMRD: begin
        mem_read = 1'b1;
        adr_src  = 1'b1;
      end
      C_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      C_MEMWR: begin
        mem_write  = 1'b1;
        adr_src    = 1'b1;
        instr_done = mem_ready;
      end
      C_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      C_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b11;
      end
      C_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      C_BEQ: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        instr_done = 1'b1;
        pc_write   = zero;
      end
      C_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      default: begin
      end
    endcase
    // Reset drops any in-flight memory request without waiting for a clock.
    if (rst) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      adr_src    = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      result_src = 2'b00;
      instr_done = 1'b0;
    end
  end

  assign illegal   = r_illegal & ~rst;
  assign dbg_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Purpose  : Self-checking bench for multicycle_control (vector table plus
//            scoreboard, with hand-written reset corner cases).
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, adr_src, mem_read, mem_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic       instr_done, illegal;
  logic [3:0] dbg_state;

  multicycle_control #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .result_src(result_src), .instr_done(instr_done), .illegal(illegal),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  logic [15:0] obs;
  assign obs = {pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
                alu_src_a, alu_src_b, alu_op, result_src, instr_done, illegal};

  typedef struct {
    logic [6:0]  op;
    logic        z;
    logic        rdy;
    logic [3:0]  st;
    logic [15:0] out;
  } vec_t;

  typedef struct {
    logic [3:0]  st;
    logic [15:0] out;
    int          idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;
  localparam logic [6:0] OP_J = 7'b1101111;
  localparam logic [6:0] OP_X = 7'b1111111;

  function automatic logic [15:0] o(input logic pcw, irw, adr, mr, mw, rw,
                                    input logic [1:0] a, b, op, rs,
                                    input logic done, ill);
    return {pcw, irw, adr, mr, mw, rw, a, b, op, rs, done, ill};
  endfunction

  function automatic void add(input logic [6:0] op, input logic z, rdy,
                              input logic [3:0] st, input logic [15:0] out);
    vecs.push_back('{op, z, rdy, st, out});
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, check at the falling edge.
  task automatic step(input int idx, input vec_t v);
    exp_t e;
    opcode    = v.op;
    zero      = v.z;
    mem_ready = v.rdy;
    sb.push_back('{v.st, v.out, idx});
    @(negedge clk);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL row%0d scoreboard: got empty queue expected entry", idx);
    end else begin
      e = sb.pop_front();
      chk($sformatf("row%0d state", e.idx), {12'd0, dbg_state}, {12'd0, e.st});
      chk($sformatf("row%0d outputs", e.idx), obs, e.out);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] f_go, f_stall, dec, ma, mr, mwb, mwr, wb, tr;
    f_go    = o(1,1,0,1,0,0,2'b00,2'b10,2'b00,2'b10,0,0);
    f_stall = o(0,0,0,1,0,0,2'b00,2'b10,2'b00,2'b10,0,0);
    dec     = o(0,0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,0,0);
    ma      = o(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,0,0);
    mr      = o(0,0,1,1,0,0,2'b00,2'b00,2'b00,2'b00,0,0);
    mwb     = o(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b01,1,0);
    mwr     = o(0,0,1,0,1,0,2'b00,2'b00,2'b00,2'b00,0,0);
    wb      = o(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,1,0);
    tr      = o(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,1);

    // R-type: 0,1,6,8
    add(OP_R,0,1,4'd0,f_go); add(OP_R,0,1,4'd1,dec);
    add(OP_R,0,1,4'd6,o(0,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,0,0));
    add(OP_R,0,1,4'd8,wb);
    // lw with a fetch stall and two MEMRD wait cycles
    add(OP_L,0,0,4'd0,f_stall); add(OP_L,0,1,4'd0,f_go); add(OP_L,0,1,4'd1,dec);
    add(OP_L,0,0,4'd2,ma);
    add(OP_L,0,0,4'd3,mr); add(OP_L,0,0,4'd3,mr); add(OP_L,0,1,4'd3,mr);
    add(OP_L,0,1,4'd4,mwb);
    // beq taken, then not taken
    add(OP_B,1,1,4'd0,f_go); add(OP_B,1,1,4'd1,dec);
    add(OP_B,1,1,4'd9,o(1,0,0,0,0,0,2'b10,2'b00,2'b01,2'b00,1,0));
    add(OP_B,0,1,4'd0,f_go); add(OP_B,0,1,4'd1,dec);
    add(OP_B,0,1,4'd9,o(0,0,0,0,0,0,2'b10,2'b00,2'b01,2'b00,1,0));
    // I-type; opcode garbage in ALUWB must not matter
    add(OP_I,0,1,4'd0,f_go); add(OP_I,0,1,4'd1,dec);
    add(OP_I,0,1,4'd7,o(0,0,0,0,0,0,2'b10,2'b01,2'b11,2'b00,0,0));
    add(OP_X,0,1,4'd8,wb);
    // sw with one wait cycle
    add(OP_S,0,1,4'd0,f_go); add(OP_S,0,1,4'd1,dec); add(OP_S,0,1,4'd2,ma);
    add(OP_S,0,0,4'd5,mwr);
    add(OP_S,0,1,4'd5,o(0,0,1,0,1,0,2'b00,2'b00,2'b00,2'b00,1,0));
    // jal
    add(OP_J,0,1,4'd0,f_go); add(OP_J,0,1,4'd1,dec);
    add(OP_J,0,1,4'd10,o(1,0,0,0,0,0,2'b01,2'b10,2'b00,2'b00,0,0));
    add(OP_J,0,1,4'd8,wb);
    // illegal opcode -> TRAP, absorbing for 10 cycles of arbitrary inputs
    add(OP_X,0,1,4'd0,f_go); add(OP_X,0,1,4'd1,dec); add(OP_X,0,1,4'd11,tr);
    for (int k = 0; k < 10; k++) begin
      add(7'(k * 13), k[0], k[1], 4'd11, tr);
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset state", {12'd0, dbg_state}, 16'd0);
    chk("reset outputs", obs, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(i, vecs[i]);
    end

    // rst pulse out of TRAP clears illegal immediately
    rst = 1'b1;
    #1;
    chk("trap rst state", {12'd0, dbg_state}, 16'd0);
    chk("trap rst outputs", obs, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // rst in the middle of a MEMWR wait
    step(100, '{OP_S,1'b0,1'b1,4'd0,f_go});
    step(101, '{OP_S,1'b0,1'b1,4'd1,dec});
    step(102, '{OP_S,1'b0,1'b1,4'd2,ma});
    step(103, '{OP_S,1'b0,1'b0,4'd5,mwr});
    chk("memwr wait mem_write", {15'd0, mem_write}, 16'd1);
    rst = 1'b1;
    #1;
    chk("memwr rst mem_write", {15'd0, mem_write}, 16'd0);
    chk("memwr rst state", {12'd0, dbg_state}, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(104, '{OP_S,1'b0,1'b0,4'd0,f_stall});
    step(105, '{OP_S,1'b0,1'b0,4'd0,f_stall});
    step(106, '{OP_S,1'b0,1'b1,4'd0,f_go});
    step(107, '{OP_S,1'b0,1'b1,4'd1,dec});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
